// File: rtl/dec_fpr_pkg.sv
// Shared types for the FP register-file write-side controller:
// writeback record, bank-switch FSM states and the default FP width.
package dec_fpr_pkg;

  localparam int FLEN = 64;

  typedef struct packed {
    logic [4:0]      waddr;
    logic [FLEN-1:0] wd;
  } fpr_wb_t;

  typedef enum logic [1:0] {
    BANK_IDLE   = 2'd0,
    BANK_DRAIN  = 2'd1,
    BANK_SWITCH = 2'd2,
    BANK_DONE   = 2'd3
  } bank_state_e;

endpackage

// File: rtl/dec_fpr_wb_fifo.sv
// Long-latency writeback FIFO: up to two pushes and two pops per cycle,
// exposes the head and the entry behind it plus occupancy/free counts.
module dec_fpr_wb_fifo #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push0_en,
  input  dec_fpr_pkg::fpr_wb_t    push0_data,
  input  logic                    push1_en,
  input  dec_fpr_pkg::fpr_wb_t    push1_data,
  input  logic [1:0]              pop_cnt,
  output dec_fpr_pkg::fpr_wb_t    head,
  output dec_fpr_pkg::fpr_wb_t    head_nxt,
  output logic [CW-1:0]           count,
  output logic [CW-1:0]           free
);
  import dec_fpr_pkg::*;

  localparam int AW = $clog2(DEPTH);

  fpr_wb_t       mem_r [DEPTH];
  logic [AW-1:0] rd_ptr_r;
  logic [AW-1:0] wr_ptr_r;
  logic [CW-1:0] count_r;
  logic [1:0]    push_n_s;

  assign push_n_s = {1'b0, push0_en} + {1'b0, push1_en};
  assign head     = mem_r[rd_ptr_r];
  assign head_nxt = mem_r[rd_ptr_r + AW'(1'b1)];
  assign count    = count_r;
  assign free     = CW'(DEPTH) - count_r;

  // Pointer and occupancy update; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_r <= {AW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      rd_ptr_r <= rd_ptr_r + AW'(pop_cnt);
      wr_ptr_r <= wr_ptr_r + AW'(push_n_s);
      count_r  <= count_r - CW'(pop_cnt) + CW'(push_n_s);
    end
  end

  // Entry storage; push1 is only ever used together with push0.
  always_ff @(posedge clk) begin
    if (push0_en) begin
      mem_r[wr_ptr_r] <= push0_data;
    end
    if (push1_en) begin
      mem_r[wr_ptr_r + AW'(1'b1)] <= push1_data;
    end
  end

endmodule

// File: rtl/dec_fpr_wb_arb.sv
// FP register-file write arbiter: merges pipe, divide and load writebacks
// onto two registered write ports and sequences FPR bank switches.
module dec_fpr_wb_arb #(
  parameter int FLEN           = dec_fpr_pkg::FLEN,
  parameter int DEPTH          = 4,
  parameter int FPR_BANKS_LOG2 = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      p0_wen,
  input  logic [4:0]                p0_waddr,
  input  logic [FLEN-1:0]           p0_wd,
  input  logic                      p1_wen,
  input  logic [4:0]                p1_waddr,
  input  logic [FLEN-1:0]           p1_wd,
  input  logic                      div_valid,
  input  logic [4:0]                div_waddr,
  input  logic [FLEN-1:0]           div_wd,
  output logic                      div_ready,
  input  logic                      ld_valid,
  input  logic [4:0]                ld_waddr,
  input  logic [FLEN-1:0]           ld_wd,
  output logic                      ld_ready,
  input  logic                      bank_sw_req,
  input  logic [FPR_BANKS_LOG2-1:0] bank_sw_id,
  output logic                      bank_sw_done,
  output logic                      wen0,
  output logic [4:0]                waddr0,
  output logic [FLEN-1:0]           wd0,
  output logic                      wen1,
  output logic [4:0]                waddr1,
  output logic [FLEN-1:0]           wd1,
  output logic                      wen_bank_id,
  output logic [FPR_BANKS_LOG2-1:0] wr_bank_id,
  output logic                      busy
);
  import dec_fpr_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  bank_state_e               state_r, state_s;
  logic [FPR_BANKS_LOG2-1:0] bank_id_r;
  fpr_wb_t                   head_s, nxt_s, push0_data_s, push1_data_s, sel0_s, sel1_s;
  logic [CW-1:0]             cnt_s, free_s, free_after_s;
  logic [1:0]                pop_cnt_s;
  logic                      p0_go_s, p1_go_s, head_go_s, nxt_go_s, head_to_p1_s;
  logic                      sel0_v_s, sel1_v_s, idle_s, ld_push_s, div_push_s;

  dec_fpr_wb_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push0_en   (ld_push_s | div_push_s),
    .push0_data (push0_data_s),
    .push1_en   (ld_push_s & div_push_s),
    .push1_data (push1_data_s),
    .pop_cnt    (pop_cnt_s),
    .head       (head_s),
    .head_nxt   (nxt_s),
    .count      (cnt_s),
    .free       (free_s)
  );

  assign idle_s = (state_r == BANK_IDLE);
  assign busy   = (cnt_s != {CW{1'b0}}) || !idle_s;

  // Port selection: pipes own their port; FIFO head/next fill idle ports
  // in order, never duplicating an address already issued this cycle.
  always_comb begin
    p1_go_s      = p1_wen && (p1_waddr != 5'd0);
    p0_go_s      = p0_wen && (p0_waddr != 5'd0) && !(p1_go_s && (p1_waddr == p0_waddr));
    head_go_s    = 1'b0;
    nxt_go_s     = 1'b0;
    head_to_p1_s = 1'b0;
    if ((cnt_s != {CW{1'b0}}) && !(p0_go_s && (head_s.waddr == p0_waddr))
        && !(p1_go_s && (head_s.waddr == p1_waddr))) begin
      if (!p0_go_s) begin
        head_go_s = 1'b1;
        if (!p1_go_s && (cnt_s >= CW'(2'd2)) && (nxt_s.waddr != head_s.waddr)) begin
          nxt_go_s = 1'b1;
        end else begin
          nxt_go_s = 1'b0;
        end
      end else if (!p1_go_s) begin
        head_go_s    = 1'b1;
        head_to_p1_s = 1'b1;
      end else begin
        head_go_s = 1'b0;
      end
    end else begin
      head_go_s = 1'b0;
    end
    pop_cnt_s = {1'b0, head_go_s} + {1'b0, nxt_go_s};

    sel0_v_s = p0_go_s || (head_go_s && !head_to_p1_s);
    if (p0_go_s) begin
      sel0_s = '{waddr: p0_waddr, wd: p0_wd};
    end else begin
      sel0_s = head_s;
    end
    sel1_v_s = p1_go_s || head_to_p1_s || nxt_go_s;
    if (p1_go_s) begin
      sel1_s = '{waddr: p1_waddr, wd: p1_wd};
    end else if (head_to_p1_s) begin
      sel1_s = head_s;
    end else begin
      sel1_s = nxt_s;
    end
  end

  // Push acceptance counts this cycle's pops first; load enqueues ahead of divide.
  always_comb begin
    free_after_s = free_s + CW'(pop_cnt_s);
    ld_ready     = idle_s && (free_after_s >= CW'(1'b1));
    if (ld_valid) begin
      div_ready = idle_s && (free_after_s >= CW'(2'd2));
    end else begin
      div_ready = idle_s && (free_after_s >= CW'(1'b1));
    end
    ld_push_s    = ld_valid && ld_ready && (ld_waddr != 5'd0);
    div_push_s   = div_valid && div_ready && (div_waddr != 5'd0);
    push1_data_s = '{waddr: div_waddr, wd: div_wd};
    if (ld_push_s) begin
      push0_data_s = '{waddr: ld_waddr, wd: ld_wd};
    end else begin
      push0_data_s = push1_data_s;
    end
  end

  // Bank-switch next state: drain waits until nothing is queued or in flight.
  always_comb begin
    state_s = state_r;
    case (state_r)
      BANK_IDLE: begin
        if (bank_sw_req) state_s = BANK_DRAIN;
        else             state_s = BANK_IDLE;
      end
      BANK_DRAIN: begin
        if ((cnt_s == {CW{1'b0}}) && !p0_wen && !p1_wen && !wen0 && !wen1) state_s = BANK_SWITCH;
        else                                                                state_s = BANK_DRAIN;
      end
      BANK_SWITCH: state_s = BANK_DONE;
      BANK_DONE:   state_s = BANK_IDLE;
      default:     state_s = BANK_IDLE;
    endcase
  end

  // Bank FSM state, captured target id and the bank strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= BANK_IDLE;
      bank_id_r    <= {FPR_BANKS_LOG2{1'b0}};
      wen_bank_id  <= 1'b0;
      wr_bank_id   <= {FPR_BANKS_LOG2{1'b0}};
      bank_sw_done <= 1'b0;
    end else begin
      state_r <= state_s;
      if (idle_s && bank_sw_req) bank_id_r <= bank_sw_id;
      wen_bank_id <= (state_s == BANK_SWITCH);
      if (state_s == BANK_SWITCH) wr_bank_id <= bank_id_r;
      bank_sw_done <= (state_s == BANK_DONE);
    end
  end

  // Registered regfile write ports; address/data hold when the port is idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wen0   <= 1'b0;
      waddr0 <= 5'd0;
      wd0    <= {FLEN{1'b0}};
      wen1   <= 1'b0;
      waddr1 <= 5'd0;
      wd1    <= {FLEN{1'b0}};
    end else begin
      wen0 <= sel0_v_s;
      wen1 <= sel1_v_s;
      if (sel0_v_s) begin
        waddr0 <= sel0_s.waddr;
        wd0    <= sel0_s.wd;
      end
      if (sel1_v_s) begin
        waddr1 <= sel1_s.waddr;
        wd1    <= sel1_s.wd;
      end
    end
  end

endmodule

// File: tb/tb_dec_fpr_wb_arb.sv
// Bench for dec_fpr_wb_arb: pipe-only vector table, directed FIFO/bank
// sequences and random traffic against a queue-based reference model.
module tb_dec_fpr_wb_arb;

  localparam int DEPTH = 4;

  logic        clk, rst;
  logic        p0_wen, p1_wen, div_valid, ld_valid, bank_sw_req;
  logic [4:0]  p0_waddr, p1_waddr, div_waddr, ld_waddr;
  logic [63:0] p0_wd, p1_wd, div_wd, ld_wd;
  logic [0:0]  bank_sw_id;
  logic        div_ready, ld_ready, bank_sw_done, wen0, wen1, wen_bank_id, busy;
  logic [4:0]  waddr0, waddr1;
  logic [63:0] wd0, wd1;
  logic [0:0]  wr_bank_id;

  dec_fpr_wb_arb #(.FLEN(64), .DEPTH(DEPTH), .FPR_BANKS_LOG2(1)) dut (
    .clk(clk), .rst(rst),
    .p0_wen(p0_wen), .p0_waddr(p0_waddr), .p0_wd(p0_wd),
    .p1_wen(p1_wen), .p1_waddr(p1_waddr), .p1_wd(p1_wd),
    .div_valid(div_valid), .div_waddr(div_waddr), .div_wd(div_wd), .div_ready(div_ready),
    .ld_valid(ld_valid), .ld_waddr(ld_waddr), .ld_wd(ld_wd), .ld_ready(ld_ready),
    .bank_sw_req(bank_sw_req), .bank_sw_id(bank_sw_id), .bank_sw_done(bank_sw_done),
    .wen0(wen0), .waddr0(waddr0), .wd0(wd0),
    .wen1(wen1), .waddr1(waddr1), .wd1(wd1),
    .wen_bank_id(wen_bank_id), .wr_bank_id(wr_bank_id), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [4:0] a; logic [63:0] d; } ent_t;
  typedef struct {
    logic p0w; logic [4:0] p0a; logic [63:0] p0d;
    logic p1w; logic [4:0] p1a; logic [63:0] p1d;
    logic w0;  logic [4:0] a0;  logic [63:0] d0;
    logic w1;  logic [4:0] a1;  logic [63:0] d1;
  } vec_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  ent_t        q[$];
  bit          m_idle;
  logic        e_w0, e_w1;
  logic [4:0]  e_a0, e_a1;
  logic [63:0] e_d0, e_d1;
  vec_t        vt[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    p0_wen = 1'b0; p0_waddr = 5'd0; p0_wd = 64'd0;
    p1_wen = 1'b0; p1_waddr = 5'd0; p1_wd = 64'd0;
    div_valid = 1'b0; div_waddr = 5'd0; div_wd = 64'd0;
    ld_valid = 1'b0; ld_waddr = 5'd0; ld_wd = 64'd0;
    bank_sw_req = 1'b0; bank_sw_id = 1'b0;
  endtask

  // Reference: writes this cycle never share an address, FIFO order is kept,
  // pipes own their own ports, queue capacity is DEPTH with pops counted first.
  task automatic model_eval();
    bit         g0, g1;
    int         fp[$];
    logic [4:0] used[$];
    int         pops, fr, port;
    bit         exp_ld, exp_div;
    #1;
    chk("busy", busy, (q.size() != 0) || !m_idle);
    g1 = p1_wen && (p1_waddr != 5'd0);
    g0 = p0_wen && (p0_waddr != 5'd0) && !(g1 && (p1_waddr == p0_waddr));
    e_w0 = g0; e_a0 = p0_waddr; e_d0 = p0_wd;
    e_w1 = g1; e_a1 = p1_waddr; e_d1 = p1_wd;
    if (!g0) fp.push_back(0); else used.push_back(p0_waddr);
    if (!g1) fp.push_back(1); else used.push_back(p1_waddr);
    pops = 0;
    for (int i = 0; i < 2 && i < q.size(); i++) begin
      bit clash;
      clash = 1'b0;
      foreach (used[k]) if (used[k] == q[i].a) clash = 1'b1;
      if (fp.size() == 0 || clash) break;
      port = fp.pop_front();
      if (port == 0) begin e_w0 = 1'b1; e_a0 = q[i].a; e_d0 = q[i].d; end
      else           begin e_w1 = 1'b1; e_a1 = q[i].a; e_d1 = q[i].d; end
      used.push_back(q[i].a);
      pops++;
    end
    fr      = DEPTH - q.size() + pops;
    exp_ld  = m_idle && (fr >= 1);
    exp_div = m_idle && (fr >= (ld_valid ? 2 : 1));
    chk("ld_ready", ld_ready, exp_ld);
    chk("div_ready", div_ready, exp_div);
    repeat (pops) void'(q.pop_front());
    if (ld_valid && exp_ld && ld_waddr != 5'd0) q.push_back('{a: ld_waddr, d: ld_wd});
    if (div_valid && exp_div && div_waddr != 5'd0) q.push_back('{a: div_waddr, d: div_wd});
  endtask

  task automatic check_regs();
    chk("wen0", wen0, e_w0);
    if (e_w0) begin chk("waddr0", waddr0, e_a0); chk("wd0", wd0, e_d0); end
    chk("wen1", wen1, e_w1);
    if (e_w1) begin chk("waddr1", waddr1, e_a1); chk("wd1", wd1, e_d1); end
  endtask

  task automatic tick();
    model_eval();
    @(posedge clk);
    @(negedge clk);
    check_regs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    q.delete();
    e_w0 = 1'b0; e_w1 = 1'b0; m_idle = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    idle_inputs();
    do_reset();
    #1;
    chk("rst_wen0", wen0, 1'b0);
    chk("rst_wen1", wen1, 1'b0);
    chk("rst_waddr0", waddr0, 5'd0);
    chk("rst_wd1", wd1, 64'd0);
    chk("rst_div_ready", div_ready, 1'b1);
    chk("rst_ld_ready", ld_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_wr_bank_id", wr_bank_id, 1'b0);
    chk("rst_wen_bank_id", wen_bank_id, 1'b0);
    chk("rst_bank_sw_done", bank_sw_done, 1'b0);
    @(negedge clk);

    // Pipe-only vectors
    vt[0] = '{1'b1, 5'd3,  64'hA,   1'b1, 5'd3, 64'hB, 1'b0, 5'd0,  64'h0,   1'b1, 5'd3, 64'hB};
    vt[1] = '{1'b1, 5'd4,  64'h1,   1'b1, 5'd5, 64'h2, 1'b1, 5'd4,  64'h1,   1'b1, 5'd5, 64'h2};
    vt[2] = '{1'b1, 5'd0,  64'h9,   1'b1, 5'd6, 64'h3, 1'b0, 5'd0,  64'h0,   1'b1, 5'd6, 64'h3};
    vt[3] = '{1'b1, 5'd7,  64'h4,   1'b0, 5'd7, 64'h5, 1'b1, 5'd7,  64'h4,   1'b0, 5'd0, 64'h0};
    vt[4] = '{1'b1, 5'd0,  64'h6,   1'b1, 5'd0, 64'h7, 1'b0, 5'd0,  64'h0,   1'b0, 5'd0, 64'h0};
    vt[5] = '{1'b1, 5'd31, 64'hFF,  1'b1, 5'd0, 64'h8, 1'b1, 5'd31, 64'hFF,  1'b0, 5'd0, 64'h0};
    for (int i = 0; i < 6; i++) begin
      idle_inputs();
      p0_wen = vt[i].p0w; p0_waddr = vt[i].p0a; p0_wd = vt[i].p0d;
      p1_wen = vt[i].p1w; p1_waddr = vt[i].p1a; p1_wd = vt[i].p1d;
      tick();
      chk("vec_wen0", wen0, vt[i].w0);
      if (vt[i].w0) begin chk("vec_waddr0", waddr0, vt[i].a0); chk("vec_wd0", wd0, vt[i].d0); end
      chk("vec_wen1", wen1, vt[i].w1);
      if (vt[i].w1) begin chk("vec_waddr1", waddr1, vt[i].a1); chk("vec_wd1", wd1, vt[i].d1); end
    end

    // Load and divide together: load lands on port 0 two cycles later
    idle_inputs();
    ld_valid = 1'b1; ld_waddr = 5'd5; ld_wd = 64'h11;
    div_valid = 1'b1; div_waddr = 5'd6; div_wd = 64'h22;
    tick();
    idle_inputs();
    #1 chk("pair_busy", busy, 1'b1);
    tick();
    chk("pair_waddr0", waddr0, 5'd5);
    chk("pair_wd0", wd0, 64'h11);
    chk("pair_waddr1", waddr1, 5'd6);
    chk("pair_wd1", wd1, 64'h22);
    tick();

    // Fill the FIFO while both pipes are busy, then drain in order
    for (int i = 0; i < 3; i++) begin
      p0_wen = 1'b1; p0_waddr = 5'd1; p0_wd = 64'(100 + i);
      p1_wen = 1'b1; p1_waddr = 5'd2; p1_wd = 64'(200 + i);
      ld_valid = 1'b1; ld_waddr = 5'(10 + i); ld_wd = 64'(16'h1000 + i);
      div_valid = 1'b1; div_waddr = 5'(20 + i); div_wd = 64'(16'h2000 + i);
      tick();
    end
    #1;
    chk("full_ld_ready", ld_ready, 1'b0);
    chk("full_div_ready", div_ready, 1'b0);
    idle_inputs();
    tick();
    chk("drain0_waddr0", waddr0, 5'd10);
    chk("drain0_waddr1", waddr1, 5'd20);
    tick();
    chk("drain1_waddr0", waddr0, 5'd11);
    chk("drain1_waddr1", waddr1, 5'd21);
    tick();

    // Head held behind a same-address pipe write; address 0 load vanishes
    ld_valid = 1'b1; ld_waddr = 5'd7; ld_wd = 64'h77;
    tick();
    idle_inputs();
    p0_wen = 1'b1; p0_waddr = 5'd7; p0_wd = 64'h55;
    ld_valid = 1'b1; ld_waddr = 5'd0; ld_wd = 64'h99;
    tick();
    chk("hold_wd0", wd0, 64'h55);
    chk("hold_wen1", wen1, 1'b0);
    idle_inputs();
    tick();
    chk("held_wen0", wen0, 1'b1);
    chk("held_waddr0", waddr0, 5'd7);
    chk("held_wd0", wd0, 64'h77);
    tick();
    tick();

    // Bank switch with two entries queued
    ld_valid = 1'b1; ld_waddr = 5'd12; ld_wd = 64'hC;
    div_valid = 1'b1; div_waddr = 5'd13; div_wd = 64'hD;
    tick();
    idle_inputs();
    bank_sw_req = 1'b1; bank_sw_id = 1'b1;
    tick();
    m_idle = 1'b0;
    bank_sw_req = 1'b0;
    chk("bsw_strobe_early0", wen_bank_id, 1'b0);
    tick();
    chk("bsw_strobe_early1", wen_bank_id, 1'b0);
    tick();
    chk("bsw_strobe", wen_bank_id, 1'b1);
    chk("bsw_id", wr_bank_id, 1'b1);
    chk("bsw_done_early", bank_sw_done, 1'b0);
    tick();
    chk("bsw_strobe_once", wen_bank_id, 1'b0);
    chk("bsw_done", bank_sw_done, 1'b1);
    tick();
    m_idle = 1'b1;
    chk("bsw_done_once", bank_sw_done, 1'b0);
    #1 chk("bsw_busy", busy, 1'b0);

    // Random traffic, with a reset in the middle
    for (int n = 0; n < 400; n++) begin
      p0_wen = ($urandom_range(0, 2) == 0); p0_waddr = 5'($urandom_range(0, 7)); p0_wd = {$urandom, $urandom};
      p1_wen = ($urandom_range(0, 2) == 0); p1_waddr = 5'($urandom_range(0, 7)); p1_wd = {$urandom, $urandom};
      ld_valid = ($urandom_range(0, 1) == 0); ld_waddr = 5'($urandom_range(0, 7)); ld_wd = {$urandom, $urandom};
      div_valid = ($urandom_range(0, 2) == 0); div_waddr = 5'($urandom_range(0, 7)); div_wd = {$urandom, $urandom};
      tick();
      if (n == 200) begin
        do_reset();
        #1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_wen0", wen0, 1'b0);
        chk("midrst_wen1", wen1, 1'b0);
        @(negedge clk);
      end
    end
    idle_inputs();
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
